// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Package     : core_pkg
// Description : Shared RV32I definitions: data width, reset PC, fetch word
//               stride, the prefetch FIFO entry type and base opcodes.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] WORD_STRIDE      = 32'd4;

    // One buffered instruction: the address it was fetched from plus the word.
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

    // RV32I base opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    // Clear the byte offset of an address (instructions are word aligned).
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_fifo
// Description : Synchronous FIFO of fetch entries (address + instruction word).
//               Flush empties the queue and wins over a same-cycle push.
//               Push and pop in the same cycle are allowed at any occupancy,
//               including full (the head is read before the write lands).
// Ports       : clk        - clock
//               res        - synchronous active-low reset
//               flush      - discard all entries
//               push       - write push_entry at the tail
//               push_entry - entry to write
//               pop        - drop the head entry
//               head       - current head entry (valid when !empty)
//               count      - number of entries held (0..DEPTH)
//               empty      - no entries held
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_entry,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t          store [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           cnt;

    always_ff @(posedge clk) begin
        if (!res || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; cnt alone decides what is valid.
    always_ff @(posedge clk) begin
        if (res && push && !flush) begin
            store[wr_ptr] <= push_entry;
        end
    end

    assign head  = store[rd_ptr];
    assign count = cnt;
    assign empty = (cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ifetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_prefetch
// Description : Instruction prefetch buffer in front of the RV32I core.
//               Streams sequential fetches from a pipelined instruction memory
//               (req/gnt issue, in-order rvalid) into a small FIFO and serves
//               the core's next PC from the FIFO head. A core address that does
//               not match the next buffered/expected word is a redirect: the
//               FIFO is flushed, in-flight words are marked for discard and
//               fetching restarts at the new address on the following cycle.
// Ports       : clk        - clock, all state on rising edge
//               res        - synchronous active-low reset
//               core_addr  - address of the instruction the core takes next
//               core_data  - instruction word for core_addr (0 when no hit)
//               core_halt  - core must stall (no hit, or ext_halt)
//               ext_halt   - external stall; blocks pop, not fetch
//               mem_req    - fetch request valid
//               mem_addr   - fetch address, word aligned
//               mem_gnt    - request accepted this cycle
//               mem_rvalid - response valid (in issue order)
//               mem_rdata  - response word
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_prefetch
    import core_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        res,
    input  logic [31:0] core_addr,
    output logic [31:0] core_data,
    output logic        core_halt,
    input  logic        ext_halt,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]   pf_addr;      // next address to request
    logic [31:0]   ret_addr;     // address of the next response that is kept
    logic [CW-1:0] outstanding;  // issued, not yet returned
    logic [CW-1:0] drop;         // returns still to be discarded

    // ------------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------------
    fetch_entry_t  fifo_head;
    fetch_entry_t  push_entry;
    logic [CW-1:0] fifo_count;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    // ------------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------------
    logic [31:0]   core_word;
    logic          hit;
    logic          redirect;
    logic          room;
    logic          issue;
    logic [CW-1:0] outstanding_nxt;

    assign core_word = word_align(core_addr);

    // Everything core- and memory-facing is masked while reset is held so the
    // outputs read idle from the first reset edge regardless of stale state.
    assign hit = res && !fifo_empty
                 && (fifo_head.addr[31:2] == core_word[31:2]);

    // With a non-empty FIFO the head must match. With an empty FIFO the only
    // word still coming for us is the one at ret_addr; anything else is a jump.
    assign redirect = res && (fifo_empty ? (ret_addr[31:2] != core_word[31:2])
                                         : (fifo_head.addr[31:2] != core_word[31:2]));

    assign core_data = hit ? fifo_head.data : 32'h0;
    assign core_halt = !hit || ext_halt;
    assign pop       = hit && !ext_halt;

    // Buffered plus in-flight words never exceed DEPTH, so a response always
    // has a free slot and the FIFO cannot overflow.
    assign room     = ({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_W;
    assign mem_req  = res && !redirect && room;
    assign mem_addr = pf_addr;
    assign issue    = mem_req && mem_gnt;

    assign push       = mem_rvalid && (drop == '0);
    assign push_entry = '{addr: ret_addr, data: mem_rdata};

    assign outstanding_nxt = outstanding + CW'(issue) - CW'(mem_rvalid);

    ifetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .res        (res),
        .flush      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (fifo_head),
        .count      (fifo_count),
        .empty      (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!res) begin
            pf_addr     <= word_align(RESET_PC);
            ret_addr    <= word_align(RESET_PC);
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect) begin
                pf_addr  <= core_word;
                ret_addr <= core_word;
                // Every word still in flight after this edge belongs to the
                // abandoned stream. A response arriving now is consumed this
                // cycle (flushed or counted against drop), so it is excluded;
                // no grant happens because mem_req is held low.
                drop     <= outstanding_nxt;
            end else begin
                if (issue) begin
                    pf_addr <= pf_addr + WORD_STRIDE;
                end
                if (push) begin
                    ret_addr <= ret_addr + WORD_STRIDE;
                end
                if (mem_rvalid && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

    // A response with nothing outstanding means the memory and this block
    // disagree about the request stream.
    a_rvalid_outstanding : assert property (@(posedge clk) disable iff (!res)
        !(mem_rvalid && (outstanding == '0)));

    // Compressed instructions are not supported; the core PC stays aligned.
    a_core_aligned : assert property (@(posedge clk) disable iff (!res)
        (core_addr[1:0] == 2'b00));

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_prefetch
// Description : Directed + randomised checks of ifetch_prefetch against a
//               behavioural pipelined instruction memory and a PC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_prefetch;

    localparam int DEPTH = 4;

    logic        clk;
    logic        res;
    logic [31:0] core_addr;
    logic [31:0] core_data;
    logic        core_halt;
    logic        ext_halt;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    ifetch_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0)
    ) dut (
        .clk        (clk),
        .res        (res),
        .core_addr  (core_addr),
        .core_data  (core_data),
        .core_halt  (core_halt),
        .ext_halt   (ext_halt),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word content is a fixed function of its address.
    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    int total = 0;
    int bad   = 0;

    // ------------------------------------------------------------------------
    // Pipelined memory model: records grants, returns words in order after a
    // latency in [lat_min, lat_max], at most one per cycle.
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pq[$];
    int          cyc      = 0;
    int          last_due = 0;
    int          n_issue  = 0;
    int          lat_min  = 1;
    int          lat_max  = 1;
    bit          gnt_rand = 1'b0;
    logic        m_issue;
    logic [31:0] m_addr;

    initial begin
        int lat;
        int d;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            #4;
            m_issue = res && mem_req && mem_gnt;
            m_addr  = mem_addr;
            @(posedge clk);
            #1;
            cyc++;
            if (!res) begin
                pq.delete();
                last_due   = 0;
                n_issue    = 0;
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h0;
            end else begin
                if (m_issue) begin
                    lat = int'($urandom_range(lat_max, lat_min));
                    d   = cyc - 1 + lat;
                    if (d < last_due) d = last_due;
                    last_due = d;
                    pq.push_back('{addr: m_addr, due: d});
                    n_issue++;
                end
                if (pq.size() > 0 && pq[0].due <= cyc) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = img(pq[0].addr);
                    void'(pq.pop_front());
                end else begin
                    mem_rvalid = 1'b0;
                    mem_rdata  = 32'h0;
                end
            end
            mem_gnt = gnt_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Checks
    // ------------------------------------------------------------------------
    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Samples taken one time unit before the active edge.
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_halt;
    logic [31:0] s_data;
    logic        s_cons;
    int          s_nissue;
    int          n_hit = 0;

    // One clock cycle: sample outputs, check any delivered word against the
    // image, then advance the core PC if the instruction was consumed.
    task automatic tick();
        @(negedge clk);
        #4;
        s_req    = mem_req;
        s_addr   = mem_addr;
        s_halt   = core_halt;
        s_data   = core_data;
        s_nissue = n_issue;
        s_cons   = res && !core_halt;
        if (s_cons) begin
            n_hit++;
            chk32("data_at_pc", core_data, img(core_addr));
        end
        if (res) begin
            chk1("outstanding_le_depth",
                 (pq.size() + (mem_rvalid ? 1 : 0)) <= DEPTH, 1'b1);
        end
        @(posedge clk);
        #1;
        if (s_cons) core_addr = core_addr + 32'd4;
    endtask

    task automatic hold_reset();
        res       = 1'b0;
        core_addr = 32'h0;
        ext_halt  = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        int hits_before;
        res       = 1'b0;
        core_addr = 32'h0;
        ext_halt  = 1'b0;

        // ---- 1: reset, then sequential stream, 1-cycle memory, gnt=1 -------
        lat_min = 1; lat_max = 1; gnt_rand = 1'b0;
        hold_reset();
        tick();
        chk1 ("rst_req",  s_req,  1'b0);
        chk1 ("rst_halt", s_halt, 1'b1);
        chk32("rst_data", s_data, 32'h0);
        res = 1'b1;
        tick();                                    // cycle 1
        chk1 ("t1_c1_req",  s_req,  1'b1);
        chk32("t1_c1_addr", s_addr, 32'h0);
        chk1 ("t1_c1_halt", s_halt, 1'b1);
        tick();                                    // cycle 2
        chk32("t1_c2_addr", s_addr, 32'h4);
        chk1 ("t1_c2_halt", s_halt, 1'b1);
        tick();                                    // cycle 3: first hit
        chk1 ("t1_c3_halt", s_halt, 1'b0);
        chk32("t1_c3_data", s_data, img(32'h0));
        for (int i = 0; i < 8; i++) begin
            tick();
            chk1 ("t1_stream_halt", s_halt, 1'b0);
            chk32("t1_stream_addr", s_addr, 32'(4 * (i + 3)));
        end

        // ---- 2: jump to 0x200 with 3 words in flight, 3-cycle memory -------
        lat_min = 3; lat_max = 3;
        hold_reset();
        res = 1'b1;
        repeat (8) tick();                         // hits 0,4,8,C in cycles 5..8
        chk32("t2_pc_before_jump", core_addr, 32'h10);
        core_addr = 32'h200;
        tick();                                    // cycle 9: redirect
        chk1 ("t2_redir_req",  s_req,  1'b0);
        chk1 ("t2_redir_halt", s_halt, 1'b1);
        tick();                                    // cycle 10: refetch
        chk1 ("t2_refetch_req",  s_req,  1'b1);
        chk32("t2_refetch_addr", s_addr, 32'h200);
        chk32("t2_c10_data",     s_data, 32'h0);
        for (int i = 0; i < 3; i++) begin          // cycles 11..13
            tick();
            chk1 ("t2_wait_halt", s_halt, 1'b1);
            chk32("t2_wait_data", s_data, 32'h0);
        end
        tick();                                    // cycle 14
        chk1 ("t2_hit_halt", s_halt, 1'b0);
        chk32("t2_hit_data", s_data, img(32'h200));

        // ---- 3: back-to-back redirects 0x40 then 0x80 ---------------------
        hold_reset();
        res = 1'b1;
        repeat (2) tick();                         // issue 0, 4
        core_addr = 32'h40;
        tick();                                    // cycle 3
        chk1("t3_redir1_req", s_req, 1'b0);
        core_addr = 32'h80;
        tick();                                    // cycle 4
        chk1("t3_redir2_req", s_req, 1'b0);
        tick();                                    // cycle 5
        chk1 ("t3_refetch_req",  s_req,  1'b1);
        chk32("t3_refetch_addr", s_addr, 32'h80);
        chk32("t3_c5_data",      s_data, 32'h0);
        for (int i = 0; i < 3; i++) begin          // cycles 6..8
            tick();
            chk1 ("t3_wait_halt", s_halt, 1'b1);
            chk32("t3_wait_data", s_data, 32'h0);
        end
        tick();                                    // cycle 9
        chk1 ("t3_hit_halt", s_halt, 1'b0);
        chk32("t3_hit_data", s_data, img(32'h80));

        // ---- 4: ext_halt held 10 cycles, FIFO fills, then drains ----------
        lat_min = 1; lat_max = 1;
        hold_reset();
        res = 1'b1;
        repeat (5) tick();                         // hits 0,4,8
        chk32("t4_pc_before_halt", core_addr, 32'hC);
        ext_halt = 1'b1;
        for (int c = 6; c <= 15; c++) begin
            tick();
            chk1 ("t4_halt",      s_halt, 1'b1);
            chk32("t4_head_data", s_data, img(32'hC));
            if (c >= 8) chk1("t4_req_blocked", s_req, 1'b0);
        end
        ext_halt = 1'b0;
        for (int k = 0; k < 4; k++) begin          // cycles 16..19
            tick();
            chk1 ("t4_drain_halt", s_halt, 1'b0);
            chk32("t4_drain_data", s_data, img(32'hC + 32'(4 * k)));
            if (k == 0) chk32("t4_issues", 32'(s_nissue), 32'd7);
        end

        // ---- 5: random grant, latency 1..5, random jumps and stalls -------
        lat_min = 1; lat_max = 5; gnt_rand = 1'b1;
        hold_reset();
        res = 1'b1;
        hits_before = n_hit;
        for (int i = 0; i < 400; i++) begin
            ext_halt = ($urandom_range(9, 0) == 0);
            tick();
            if (s_cons && $urandom_range(15, 0) == 0) begin
                core_addr = 32'h1000 + 32'($urandom_range(63, 0)) * 32'd4;
            end
        end
        ext_halt = 1'b0;
        chk1("t5_progress", (n_hit - hits_before) >= 40, 1'b1);

        // ---- 6: reset with 2 requests outstanding --------------------------
        lat_min = 3; lat_max = 3; gnt_rand = 1'b0;
        hold_reset();
        res = 1'b1;
        repeat (2) tick();                         // issue 0, 4
        res = 1'b0;
        tick();
        chk1 ("t6_rst_req",  s_req,  1'b0);
        chk1 ("t6_rst_halt", s_halt, 1'b1);
        chk32("t6_rst_data", s_data, 32'h0);
        tick();
        chk1 ("t6_rst2_req", s_req, 1'b0);
        core_addr = 32'h0;
        res = 1'b1;
        tick();                                    // cycle 1
        chk1 ("t6_restart_req",  s_req,  1'b1);
        chk32("t6_restart_addr", s_addr, 32'h0);
        tick();                                    // cycle 2
        chk32("t6_c2_addr", s_addr, 32'h4);
        repeat (2) begin                           // cycles 3, 4
            tick();
            chk1("t6_wait_halt", s_halt, 1'b1);
        end
        tick();                                    // cycle 5
        chk1 ("t6_hit_halt", s_halt, 1'b0);
        chk32("t6_hit_data", s_data, img(32'h0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
